// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Shared pixel type and default frame geometry for the Sobel path.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int PIX_W          = 8;
    localparam int DEFAULT_WIDTH  = 640;
    localparam int DEFAULT_HEIGHT = 480;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sobel_line_buffer
// Description : One video line of pixel storage, combinational read and
//               synchronous write (read returns the old word on a same-address write).
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEFAULT_WIDTH,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic [AW-1:0]    i_addr,
    input  logic             i_wr_en,
    input  logic [PIX_W-1:0] i_wr_data,
    output logic [PIX_W-1:0] o_rd_data
);

    // Contents are intentionally never reset; stale lines are masked upstream.
    pixel_t r_mem [DEPTH];

    assign o_rd_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_window.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window
// Description : Streaming 3x3 neighbourhood generator built on two line buffers.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window
    import sobel_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int CW     = 10,
    parameter int RW     = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] z0,
    output logic [PIX_W-1:0] z1,
    output logic [PIX_W-1:0] z2,
    output logic [PIX_W-1:0] z3,
    output logic [PIX_W-1:0] z4,
    output logic [PIX_W-1:0] z5,
    output logic [PIX_W-1:0] z6,
    output logic [PIX_W-1:0] z7,
    output logic [PIX_W-1:0] z8,
    output logic             window_valid
);

    localparam logic [CW-1:0] c_COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] c_COL_MIN  = CW'(2);
    localparam logic [RW-1:0] c_ROW_MIN  = RW'(2);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_lb_wr;
    logic          w_in_window;
    pixel_t        w_top_tap;
    pixel_t        w_mid_tap;
    pixel_t        r_win [9];
    logic          r_valid;

    // sof forces the accepted pixel to (0,0) without waiting for the counters.
    always_comb begin
        w_col = r_col;
        w_row = r_row;
        if (sof) begin
            w_col = '0;
            w_row = '0;
        end
    end

    assign w_lb_wr     = pix_valid && !reset;
    assign w_in_window = (w_row >= c_ROW_MIN) && (w_col >= c_COL_MIN);

    sobel_line_buffer #(
        .DEPTH (WIDTH),
        .AW    (CW)
    ) lb_top (
        .clk       (clock),
        .i_addr    (w_col),
        .i_wr_en   (w_lb_wr),
        .i_wr_data (w_mid_tap),
        .o_rd_data (w_top_tap)
    );

    sobel_line_buffer #(
        .DEPTH (WIDTH),
        .AW    (CW)
    ) lb_mid (
        .clk       (clock),
        .i_addr    (w_col),
        .i_wr_en   (w_lb_wr),
        .i_wr_data (pix_in),
        .o_rd_data (w_mid_tap)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_valid <= pix_valid && w_in_window;
            if (pix_valid) begin
                if (w_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_top_tap;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_mid_tap;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= pix_in;
            end
        end
    end

    assign z0           = r_win[0];
    assign z1           = r_win[1];
    assign z2           = r_win[2];
    assign z3           = r_win[3];
    assign z4           = r_win[4];
    assign z5           = r_win[5];
    assign z6           = r_win[6];
    assign z7           = r_win[7];
    assign z8           = r_win[8];
    assign window_valid = r_valid;

endmodule
`default_nettype wire

// File: doc/sobel_window.md
# sobel_window

Streaming 3x3 window generator that feeds the Sobel edge stage. Accepts one 8-bit grayscale pixel per qualified cycle in raster order, stores the two previous video lines in line buffers, and presents the 3x3 neighbourhood on `z0..z8` with a `window_valid` qualifier. It sits between the camera/frame-buffer pixel stream and the edge detector.

## Interface
- `WIDTH`, default 640: pixels per line; line buffer depth.
- `HEIGHT`, default 480: lines per frame.
- `CW`, default 10: column counter width; must satisfy `2^CW >= WIDTH`.
- `RW`, default 9: row counter width; must satisfy `2^RW >= HEIGHT`.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `pix_in`  in  8  unsigned grayscale pixel.
- `pix_valid`  in  1  `pix_in` is accepted this cycle.
- `sof`  in  1  start of frame; only meaningful while `pix_valid` is high; marks `pix_in` as pixel (0,0).
- `z0`..`z8`  out  8 each  window; `z0 z1 z2` = top row (row r-2), `z3 z4 z5` = middle (r-1), `z6 z7 z8` = bottom (r); within a row, left to right = columns c-2, c-1, c.
- `window_valid`  out  1  `z0..z8` form a complete in-frame window centred on (r-1, c-1).

## Operation
- Accept = `pix_valid`. Nothing advances without an accept.
- Position (r, c) of an accepted pixel:
  - `(0,0)` if `sof`.
  - Otherwise taken from the internal counters `row`, `col`.
- After an accept, the counters are advanced as follows:
  - `col` wraps `WIDTH-1 -> 0` and increments `row`.
  - `row` wraps `HEIGHT-1 -> 0`.
- Line buffers: `lb_mid` holds row r-1 and `lb_top` holds row r-2, both indexed by column. Read is combinational at address c. On accept, in the same cycle:
  - `top_tap = lb_top[c]` and `mid_tap = lb_mid[c]`.
  - Write `lb_top[c] <= mid_tap` and `lb_mid[c] <= pix_in`.
- Window shift on accept:
  - `z0<=z1`, `z1<=z2`, `z2<=top_tap`.
  - `z3<=z4`, `z4<=z5`, `z5<=mid_tap`.
  - `z6<=z7`, `z7<=z8`, `z8<=pix_in`.
- `window_valid <= accept && r>=2 && c>=2`. In every non-accept cycle it is 0.
- Windows at c=0,1 straddle the previous line's tail. The `c>=2` term suppresses them.
- Rows 0 and 1 of every frame never produce a valid window. Exactly (WIDTH-2)*(HEIGHT-2) valid windows are produced per frame.
- `sof` mid-frame: resynchronises immediately. The pixel is (0,0) and the counters continue from (0,1). No valid window is produced until row 2, column 2 of the new frame.
- Reset:
  - `row`, `col`, `z0..z8`, and `window_valid` are cleared to 0.
  - Line buffer contents are not cleared. Stale data is masked by the row>=2 rule.
  - Reset mid-frame means the next accepted pixel is (0,0), regardless of `sof`.
- `reset` and `pix_valid` asserted in the same cycle: reset wins and the pixel is dropped.

## Timing
- Latency: the window completed by the pixel accepted in cycle N appears on `z0..z8` with `window_valid=1` in cycle N+1.
- Back-to-back accepts give one window per cycle.
- During stalls (`pix_valid=0`):
  - `z0..z8` hold their values.
  - `window_valid=0`.
  - Counters and line buffers are unchanged.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values of all outputs are 0.

## Structure
- Shared package `sobel_pkg`:
  - `PIX_W = 8`.
  - Default `WIDTH` and `HEIGHT`.
  - Pixel typedef, shared with the Sobel edge stage.
- One sub-module, `sobel_line_buffer`:
  - Parameterised depth `WIDTH`, 8-bit data.
  - Combinational read, synchronous write, read-before-write at the same address.
  - Instantiated twice (`lb_top`, `lb_mid`).
- Counters, window registers and valid logic stay in the top module.

## Test plan
- WIDTH=4, HEIGHT=4, pixel value = 16*r+c, `sof` on the first pixel, no gaps:
  - First `window_valid` occurs one cycle after pixel (2,2).
  - That window is `z0..z8` = 00,01,02,10,11,12,20,21,22.
  - Exactly 4 valid windows in the frame; the last is 11,12,13,21,22,23,31,32,33.
- Same frame with random `pix_valid` gaps (0-3 idle cycles):
  - Identical window sequence.
  - `window_valid` is 0 in every idle cycle and `z*` holds.
- Two consecutive frames with `sof` only on the first:
  - No valid window during rows 0-1 of frame 2.
  - Frame 2's first window again equals the frame-1 first window values.
- `reset` pulse after pixel (2,3):
  - Outputs are 0 the next cycle.
  - Restreaming the frame without `sof` reproduces the full correct 4-window sequence.
- `sof` asserted at pixel (3,1) of frame 1: row counting restarts, and no valid window appears until the new (2,2).
- `sof` with `pix_valid=0` mid-frame: ignored; window sequence unchanged.
